digit_shift_display: RTL



---
 rtl/digit_shift_display_if.sv | 33 +++
 rtl/digit_shift_display.sv | 135 +++++++++++++
 2 files changed

// File: rtl/digit_shift_display_if.sv
// Bus between the switch front end and the digit shift display.
// Handshake: a frame starts on any rising clock edge where ready=1 and (load=1 or auto=1);
// load seen while ready=0 is dropped and flagged on overrun; upd marks a fresh disp for one cycle.
interface digit_shift_display_if #(
  parameter int DIGIT_W = 4,
  parameter int DEPTH   = 6,
  parameter int CNT_W   = 8
);
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [DIGIT_W-1:0]       data;
  logic                     load;
  logic                     auto;
  logic [1:0]               mode;
  logic                     clr;
  logic                     ready;
  logic [DEPTH*DIGIT_W-1:0] disp;
  logic                     upd;
  logic [FILL_W-1:0]        fill;
  logic [CNT_W-1:0]         frame_cnt;
  logic                     overrun;
  logic [1:0]               dbg_state;

  modport master (
    output data, load, auto, mode, clr,
    input  ready, disp, upd, fill, frame_cnt, overrun, dbg_state
  );

  modport slave (
    input  data, load, auto, mode, clr,
    output ready, disp, upd, fill, frame_cnt, overrun, dbg_state
  );
endinterface

// File: rtl/digit_shift_display.sv
// Captures a switch digit, shifts/rotates it into a DEPTH-digit register and
// refreshes a registered display bus once per frame, with an idle gap after each refresh.
module digit_shift_display #(
  parameter int DIGIT_W = 4,
  parameter int DEPTH   = 6,
  parameter int GAP     = 2,
  parameter int CNT_W   = 8
) (
  input logic                  clock,
  input logic                  reset,
  digit_shift_display_if.slave bus
);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int DW     = DEPTH * DIGIT_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_OUTPUT = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DIGIT_W-1:0] dig [DEPTH];
  logic [DIGIT_W-1:0] mem;
  logic [1:0]         mode_q;
  logic [7:0]         gap_cnt;
  logic [DW-1:0]      dig_flat;
  logic [DW-1:0]      disp_r;
  logic               upd_r;
  logic [FILL_W-1:0]  fill_r;
  logic [CNT_W-1:0]   frame_cnt_r;
  logic               overrun_r;
  logic               start;

  assign start = (state == S_IDLE) && (bus.load || bus.auto);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SHIFT;
      S_SHIFT:  state_nxt = S_OUTPUT;
      S_OUTPUT: state_nxt = (GAP == 0) ? S_IDLE : S_WAIT;
      S_WAIT:   if (gap_cnt <= 8'd1) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (bus.clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    dig_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dig_flat[i*DIGIT_W +: DIGIT_W] = dig[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) dig[i] <= '0;
      mem         <= '0;
      mode_q      <= 2'd0;
      gap_cnt     <= 8'd0;
      disp_r      <= '0;
      upd_r       <= 1'b0;
      fill_r      <= '0;
      frame_cnt_r <= '0;
      overrun_r   <= 1'b0;
    end else if (bus.clr) begin
      // Abort: the frame counter survives, everything visible is wiped.
      for (int i = 0; i < DEPTH; i++) dig[i] <= '0;
      disp_r    <= '0;
      upd_r     <= 1'b0;
      fill_r    <= '0;
      overrun_r <= 1'b0;
    end else begin
      upd_r <= 1'b0;
      if (bus.load && (state != S_IDLE)) overrun_r <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            mem    <= bus.data;
            mode_q <= bus.mode;
          end
        end
        S_SHIFT: begin
          case (mode_q)
            2'd0: begin
              dig[0] <= mem;
              for (int i = 1; i < DEPTH; i++) dig[i] <= dig[i-1];
            end
            2'd1: begin
              dig[DEPTH-1] <= mem;
              for (int i = 0; i < DEPTH - 1; i++) dig[i] <= dig[i+1];
            end
            2'd2: begin
              dig[0] <= dig[DEPTH-1];
              for (int i = 1; i < DEPTH; i++) dig[i] <= dig[i-1];
            end
            default: ;
          endcase
          // Only inserting modes add a digit; rotate and hold keep the count.
          if (!mode_q[1] && (fill_r != FILL_W'(DEPTH))) fill_r <= fill_r + FILL_W'(1);
        end
        S_OUTPUT: begin
          disp_r      <= dig_flat;
          upd_r       <= 1'b1;
          frame_cnt_r <= frame_cnt_r + CNT_W'(1);
          gap_cnt     <= 8'(GAP);
        end
        S_WAIT: begin
          gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state == S_IDLE);
  assign bus.disp      = disp_r;
  assign bus.upd       = upd_r;
  assign bus.fill      = fill_r;
  assign bus.frame_cnt = frame_cnt_r;
  assign bus.overrun   = overrun_r;
  assign bus.dbg_state = state;
endmodule
